// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types and defaults for the Wishbone master arbiter.
package wb_bus_arbiter_pkg;

    localparam int unsigned WB_TIMEOUT_CYCLES = 256;

    // Current bus owner, exported for trace/debug.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } wb_owner_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_DBG  = 2'd2
    } arb_state_t;

    // Request payload forwarded to the bus by the owner mux.
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_req_t;

endpackage

// File: rtl/wb_bus_arbiter_timeout.sv
// Watchdog counting granted cycles that have not yet seen ack/err.
module wb_timeout_counter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // Count waiting cycles; saturates at the expiry value.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Expiry is flagged during the last allowed granted cycle.
    always_comb expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-requester (core / debug) Wishbone classic master arbiter with watchdog.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_halted,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_adr_i,
    input  logic [31:0] core_dat_i,
    input  logic [3:0]  core_sel_i,
    output logic [31:0] core_dat_o,
    output logic        core_ack_o,
    output logic        core_err_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_adr_i,
    input  logic [31:0] dbg_dat_i,
    input  logic [3:0]  dbg_sel_i,
    output logic [31:0] dbg_dat_o,
    output logic        dbg_ack_o,
    output logic        dbg_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output wb_owner_t   owner_o
);

    arb_state_t state, state_nxt;
    wb_owner_t  last_grant, last_grant_nxt;
    wb_req_t    bus_req;
    logic       eff_core;
    logic       granted;
    logic       expired;
    logic       done;
    logic       rsp_ok;
    logic       rsp_err;
    logic       rsp_dat_vld;

    // Watchdog: cleared while idle, so every grant starts from zero.
    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (!granted),
        .en      (granted && !wb_ack_i && !wb_err_i),
        .expired (expired)
    );

    // Request qualification and completion decode.
    always_comb begin
        eff_core    = core_req_i & ~core_halted;
        granted     = (state != ST_IDLE);
        done        = wb_ack_i | wb_err_i | expired;
        rsp_ok      = wb_ack_i & ~wb_err_i;
        rsp_err     = wb_err_i | (expired & ~wb_ack_i);
        rsp_dat_vld = wb_ack_i | wb_err_i;
    end

    // State and round-robin history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= OWN_DBG;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state: round-robin grant from idle, hold grant until completion.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            ST_IDLE: begin
                if (eff_core && (!dbg_req_i || last_grant == OWN_DBG)) begin
                    state_nxt      = ST_CORE;
                    last_grant_nxt = OWN_CORE;
                end else if (dbg_req_i) begin
                    state_nxt      = ST_DBG;
                    last_grant_nxt = OWN_DBG;
                end
            end
            ST_CORE, ST_DBG: begin
                if (done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Owner's live request is muxed onto the bus while granted.
    always_comb begin
        bus_req  = '0;
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        owner_o  = OWN_NONE;
        case (state)
            ST_CORE: begin
                bus_req  = '{we: core_we_i, adr: core_adr_i, dat: core_dat_i, sel: core_sel_i};
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                owner_o  = OWN_CORE;
            end
            ST_DBG: begin
                bus_req  = '{we: dbg_we_i, adr: dbg_adr_i, dat: dbg_dat_i, sel: dbg_sel_i};
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                owner_o  = OWN_DBG;
            end
            default: ;
        endcase
        wb_we_o  = bus_req.we;
        wb_adr_o = bus_req.adr;
        wb_dat_o = bus_req.dat;
        wb_sel_o = bus_req.sel;
    end

    // Responses go to the owner only; a reset cycle suppresses them.
    always_comb begin
        core_ack_o = 1'b0;
        core_err_o = 1'b0;
        core_dat_o = '0;
        dbg_ack_o  = 1'b0;
        dbg_err_o  = 1'b0;
        dbg_dat_o  = '0;
        if (!rst) begin
            case (state)
                ST_CORE: begin
                    core_ack_o = rsp_ok;
                    core_err_o = rsp_err;
                    core_dat_o = rsp_dat_vld ? wb_dat_i : '0;
                end
                ST_DBG: begin
                    dbg_ack_o = rsp_ok;
                    dbg_err_o = rsp_err;
                    dbg_dat_o = rsp_dat_vld ? wb_dat_i : '0;
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Owners must hold their request until the transaction ends.
    core_req_held_a: assert property (@(posedge clk) disable iff (rst)
        (state == ST_CORE) |-> core_req_i);
    dbg_req_held_a: assert property (@(posedge clk) disable iff (rst)
        (state == ST_DBG) |-> dbg_req_i);
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios plus random traffic.
module tb_wb_bus_arbiter;
    import wb_bus_arbiter_pkg::*;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst, halted;
    logic        creq, cwe, dreq, dwe;
    logic [31:0] cadr, cdat, dadr, ddat;
    logic [3:0]  csel, dsel;
    logic [31:0] core_dat_o, dbg_dat_o;
    logic        core_ack_o, core_err_o, dbg_ack_o, dbg_err_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, ack, err;
    wb_owner_t   owner_o;

    int checks = 0;
    int errors = 0;

    // Reference model: owner (0 none, 1 core, 2 dbg), last winner, cycles already waited.
    int m_owner = 0;
    int m_last  = 2;
    int m_wait  = 0;
    bit m_c_done, m_d_done;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .core_halted(halted),
        .core_req_i(creq), .core_we_i(cwe), .core_adr_i(cadr), .core_dat_i(cdat), .core_sel_i(csel),
        .core_dat_o(core_dat_o), .core_ack_o(core_ack_o), .core_err_o(core_err_o),
        .dbg_req_i(dreq), .dbg_we_i(dwe), .dbg_adr_i(dadr), .dbg_dat_i(ddat), .dbg_sel_i(dsel),
        .dbg_dat_o(dbg_dat_o), .dbg_ack_o(dbg_ack_o), .dbg_err_o(dbg_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(ack), .wb_err_i(err), .owner_o(owner_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model for this cycle, then advance the model.
    task automatic sample();
        bit          tmo, ack_e, err_e, ec;
        logic [31:0] dat_e, a_e, d_e;
        logic [3:0]  s_e;
        logic        w_e;
        int          pick;
        #1;
        if (rst) begin
            check("rst_core_ack", 32'(core_ack_o), 0);
            check("rst_core_err", 32'(core_err_o), 0);
            check("rst_dbg_ack", 32'(dbg_ack_o), 0);
            check("rst_dbg_err", 32'(dbg_err_o), 0);
            m_owner = 0; m_last = 2; m_wait = 0;
            m_c_done = 0; m_d_done = 0;
        end else begin
            a_e = 0; d_e = 0; s_e = 0; w_e = 0;
            if (m_owner == 1) begin a_e = cadr; d_e = cdat; s_e = csel; w_e = cwe; end
            if (m_owner == 2) begin a_e = dadr; d_e = ddat; s_e = dsel; w_e = dwe; end
            check("cyc", 32'(wb_cyc_o), 32'(m_owner != 0));
            check("stb", 32'(wb_stb_o), 32'(m_owner != 0));
            check("owner", 32'(owner_o), 32'(m_owner));
            check("adr", wb_adr_o, a_e);
            check("wdat", wb_dat_o, d_e);
            check("sel", 32'(wb_sel_o), 32'(s_e));
            check("we", 32'(wb_we_o), 32'(w_e));
            tmo   = (m_owner != 0) && (m_wait + 1 == int'(T));
            ack_e = (m_owner != 0) && ack && !err;
            err_e = (m_owner != 0) && (err || (tmo && !ack));
            dat_e = ((m_owner != 0) && (ack || err)) ? wb_dat_i : 32'h0;
            check("core_ack", 32'(core_ack_o), 32'(m_owner == 1 && ack_e));
            check("core_err", 32'(core_err_o), 32'(m_owner == 1 && err_e));
            check("core_rdat", core_dat_o, (m_owner == 1) ? dat_e : 32'h0);
            check("dbg_ack", 32'(dbg_ack_o), 32'(m_owner == 2 && ack_e));
            check("dbg_err", 32'(dbg_err_o), 32'(m_owner == 2 && err_e));
            check("dbg_rdat", dbg_dat_o, (m_owner == 2) ? dat_e : 32'h0);
            m_c_done = (m_owner == 1) && (ack_e || err_e);
            m_d_done = (m_owner == 2) && (ack_e || err_e);
            if (m_owner != 0) begin
                if (ack || err || tmo) m_owner = 0;
                else m_wait++;
            end else begin
                ec = creq && !halted;
                if (ec && dreq) pick = (m_last == 1) ? 2 : 1;
                else if (ec)    pick = 1;
                else if (dreq)  pick = 2;
                else            pick = 0;
                if (pick != 0) begin
                    m_owner = pick; m_last = pick; m_wait = 0;
                end
            end
        end
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic quiet();
        creq = 0; dreq = 0; ack = 0; err = 0; halted = 0; rst = 0;
    endtask

    wb_owner_t   order [4];
    logic [31:0] order_adr [4];
    bit          cbusy, dbusy, hang;
    int          r;

    initial begin
        quiet();
        rst = 1; cwe = 0; dwe = 0; cadr = 0; cdat = 0; dadr = 0; ddat = 0;
        csel = 0; dsel = 0; wb_dat_i = 0;
        tick(); tick();
        rst = 0;

        // Core read alone, slave acks on the second granted cycle.
        creq = 1; cadr = 32'h1000_0004; cwe = 0; csel = 4'hF; cdat = 32'h0;
        tick();
        sample(); check("t1_cyc_c1", 32'(wb_cyc_o), 1); advance();
        ack = 1; wb_dat_i = 32'hCAFE_F00D;
        sample();
        check("t1_core_ack", 32'(core_ack_o), 1);
        check("t1_core_dat", core_dat_o, 32'hCAFE_F00D);
        advance();
        creq = 0; ack = 0;
        sample(); check("t1_owner_none", 32'(owner_o), 32'(OWN_NONE)); advance();

        // Tie from reset alternates CORE, DBG, CORE, DBG.
        rst = 1; tick(); rst = 0;
        creq = 1; dreq = 1; cadr = 32'hA000_0000; dadr = 32'hB000_0010;
        order = '{OWN_CORE, OWN_DBG, OWN_CORE, OWN_DBG};
        order_adr = '{32'hA000_0000, 32'hB000_0010, 32'hA000_0000, 32'hB000_0010};
        for (int i = 0; i < 4; i++) begin
            ack = 0; tick();
            ack = 1; sample();
            check("t2_order", 32'(owner_o), 32'(order[i]));
            check("t2_adr", wb_adr_o, order_adr[i]);
            advance();
        end
        ack = 0;

        // Halted core is masked; debug write appears on the bus.
        halted = 1; dwe = 1; ddat = 32'h1234_5678; dsel = 4'hF;
        for (int i = 0; i < 2; i++) begin
            ack = 0; tick();
            ack = 1; sample();
            check("t3_owner", 32'(owner_o), 32'(OWN_DBG));
            check("t3_wdat", wb_dat_o, 32'h1234_5678);
            check("t3_sel", 32'(wb_sel_o), 32'hF);
            check("t3_core_ack", 32'(core_ack_o), 0);
            advance();
        end
        quiet(); tick();

        // Watchdog expiry, then an ack landing on the expiry cycle.
        for (int v = 0; v < 2; v++) begin
            dreq = 1; tick();
            for (int k = 1; k <= int'(T); k++) begin
                ack = (v == 1) && (k == int'(T));
                sample();
                check("t4_cyc", 32'(wb_cyc_o), 1);
                check("t4_err", 32'(dbg_err_o), 32'(v == 0 && k == int'(T)));
                check("t4_ack", 32'(dbg_ack_o), 32'(v == 1 && k == int'(T)));
                advance();
            end
            dreq = 0; ack = 0;
            sample(); check("t4_cyc_drop", 32'(wb_cyc_o), 0); advance();
        end

        // Err and ack together: err wins.
        creq = 1; tick();
        ack = 1; err = 1; sample();
        check("t5_err", 32'(core_err_o), 1);
        check("t5_ack", 32'(core_ack_o), 0);
        advance();
        quiet(); tick();

        // Reset during a granted debug cycle; next tie goes to core.
        dreq = 1; tick();
        rst = 1; sample();
        check("t6_dbg_ack", 32'(dbg_ack_o), 0);
        check("t6_dbg_err", 32'(dbg_err_o), 0);
        advance();
        rst = 0; creq = 1;
        sample(); check("t6_cyc_low", 32'(wb_cyc_o), 0); advance();
        sample(); check("t6_core_first", 32'(owner_o), 32'(OWN_CORE)); advance();
        ack = 1; tick(); creq = 0; ack = 0;
        tick(); ack = 1; tick();
        quiet(); tick();

        // Random traffic against the model.
        cbusy = 0; dbusy = 0; hang = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) halted = ~halted;
            if (!cbusy && $urandom_range(0, 2) == 0) begin
                cbusy = 1; creq = 1; cadr = $urandom; cdat = $urandom;
                csel = 4'($urandom); cwe = 1'($urandom);
            end
            if (!dbusy && $urandom_range(0, 2) == 0) begin
                dbusy = 1; dreq = 1; dadr = $urandom; ddat = $urandom;
                dsel = 4'($urandom); dwe = 1'($urandom);
            end
            if (m_owner != 0) begin
                if (m_wait == 0) hang = ($urandom_range(0, 5) == 0);
                r   = int'($urandom_range(0, 19));
                ack = !hang && (r < 8 || r == 10);
                err = !hang && (r == 9 || r == 10);
            end else begin
                ack = ($urandom_range(0, 7) == 0);
                err = ($urandom_range(0, 15) == 0);
            end
            wb_dat_i = $urandom;
            tick();
            if (m_c_done) begin cbusy = 0; creq = 0; end
            if (m_d_done) begin dbusy = 0; dreq = 0; end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
